// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM access engine: FSM encodings, the default
// SRAM base address and the half-word address helper.
package sram_controller_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACC_LO = 2'd1;
    localparam logic [1:0] ST_ACC_HI = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    // SRAM half-word address: word index with the half select as the LSB.
    function automatic logic [17:0] half_addr(input logic [16:0] word, input logic hi);
        return {word, hi};
    endfunction

endpackage

// File: rtl/sram_controller.sv
// MEM-stage SRAM access engine: splits a 32-bit load/store into two 16-bit
// SRAM accesses and holds ready low until the word access completes.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned SRAM_WAIT = 1,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    localparam int unsigned   CW       = $clog2(SRAM_WAIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SRAM_WAIT - 1);

    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [CW-1:0] cnt_r;
    logic          last_s;
    logic          req_s;
    logic          acc_r_s;
    logic [31:0]   off_s;
    logic [16:0]   word_r;
    logic [16:0]   word_s;
    logic [31:0]   wdata_r;
    logic [31:0]   wdata_s;
    logic          is_wr_r;
    logic          is_wr_s;
    logic [15:0]   lo_r;
    logic          acc_s;
    logic          hi_s;
    logic [17:0]   bus_addr_s;
    logic [15:0]   bus_dq_s;
    logic          bus_oe_s;
    logic          bus_we_n_s;
    logic          unused_s;

    assign req_s    = wr_en | rd_en;
    assign last_s   = (cnt_r == LAST_CNT);
    assign acc_r_s  = (state_r == ST_ACC_LO) || (state_r == ST_ACC_HI);
    // Offset wraps at 32 bits; only the word index bits reach the SRAM.
    assign off_s    = address - BASE_ADDR;
    assign unused_s = ^{off_s[31:19], off_s[1:0]};

    // Next-state logic of the access FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) state_s = ST_ACC_LO;
                else       state_s = ST_IDLE;
            end
            ST_ACC_LO: begin
                if (last_s) state_s = ST_ACC_HI;
                else        state_s = ST_ACC_LO;
            end
            ST_ACC_HI: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_ACC_HI;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Pipeline freeze: free-running in IDLE only while no request is pending.
    always_comb begin
        case (state_r)
            ST_IDLE: ready = ~req_s;
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Pins are registered, so their next values come from the upcoming state;
    // in IDLE the request inputs are used directly as they are latched now.
    always_comb begin
        word_s  = (state_r == ST_IDLE) ? off_s[18:2] : word_r;
        wdata_s = (state_r == ST_IDLE) ? write_data  : wdata_r;
        is_wr_s = (state_r == ST_IDLE) ? wr_en       : is_wr_r;
        acc_s   = (state_s == ST_ACC_LO) || (state_s == ST_ACC_HI);
        hi_s    = (state_s == ST_ACC_HI);
        if (acc_s) begin
            bus_addr_s = half_addr(word_s, hi_s);
            bus_dq_s   = is_wr_s ? (hi_s ? wdata_s[31:16] : wdata_s[15:0]) : 16'd0;
            bus_oe_s   = is_wr_s;
            bus_we_n_s = ~is_wr_s;
        end else begin
            bus_addr_s = 18'd0;
            bus_dq_s   = 16'd0;
            bus_oe_s   = 1'b0;
            bus_we_n_s = 1'b1;
        end
    end

    // State, wait counter, request latches, read assembly and SRAM pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            word_r      <= 17'd0;
            wdata_r     <= 32'd0;
            is_wr_r     <= 1'b0;
            lo_r        <= 16'd0;
            read_data   <= 32'd0;
            sram_addr   <= 18'd0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state_r     <= state_s;
            cnt_r       <= (acc_r_s && !last_s) ? cnt_r + CW'(1) : '0;
            word_r      <= word_s;
            wdata_r     <= wdata_s;
            is_wr_r     <= is_wr_s;
            if (!is_wr_r && last_s && (state_r == ST_ACC_LO)) begin
                lo_r <= sram_dq_in;
            end
            // The word is published only once both halves are in.
            if (!is_wr_r && last_s && (state_r == ST_ACC_HI)) begin
                read_data <= {sram_dq_in, lo_r};
            end
            sram_addr   <= bus_addr_s;
            sram_dq_out <= bus_dq_s;
            sram_dq_oe  <= bus_oe_s;
            sram_we_n   <= bus_we_n_s;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: one instance with SRAM_WAIT=1 and one
// with SRAM_WAIT=3, each driven by directed and random loads/stores.
module tb_sram_controller;

    localparam logic [31:0] BASE = 32'd1024;

    typedef struct packed {
        logic        wr;
        logic [17:0] lo;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL inst%0d %s: got %h, expected %h", g, name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input int a);
        return 16'(a * 40503 + 12345);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int W = (g == 0) ? 1 : 3;

        logic        rst, wr_en, rd_en, ready, sram_dq_oe, sram_we_n, load;
        logic [31:0] address, write_data, read_data;
        logic [17:0] sram_addr;
        logic [15:0] sram_dq_out, sram_dq_in;
        logic [15:0] mem [0:1023];
        logic [15:0] ref_mem [0:1023];
        logic [31:0] last_rd;
        exp_t        q[$];
        bit          done;
        int          zeros;
        bit          post_rst;
        exp_t        me;
        logic [17:0] ea;
        logic [15:0] ed;
        logic        ew, eo;

        sram_controller #(.SRAM_WAIT(W), .BASE_ADDR(BASE)) dut (
            .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
            .address(address), .write_data(write_data), .read_data(read_data),
            .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
            .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
        );

        // Asynchronous-read SRAM with a write on each clock edge where we_n is low.
        always @(posedge clk) begin
            if (load) begin
                for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
            end else if (!sram_we_n) begin
                mem[sram_addr[9:0]] <= sram_dq_out;
            end
        end
        assign sram_dq_in = mem[sram_addr[9:0]];

        // Monitor: checks the pins every cycle and pops an expectation at each completion.
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                zeros    = 0;
                post_rst = 1'b1;
            end else begin
                if (post_rst) begin
                    chk(g, "rst_read_data", read_data, 32'd0);
                    post_rst = 1'b0;
                end
                me = (q.size() > 0) ? q[0] : '0;
                ea = 18'd0; ed = 16'd0; ew = 1'b1; eo = 1'b0;
                if (!ready && zeros >= 1 && zeros <= 2 * W) begin
                    ea = (zeros > W) ? (me.lo | 18'd1) : me.lo;
                    if (me.wr) begin
                        ed = (zeros > W) ? me.wd[31:16] : me.wd[15:0];
                        ew = 1'b0;
                        eo = 1'b1;
                    end
                end
                chk(g, "sram_addr", 32'(sram_addr), 32'(ea));
                chk(g, "sram_dq_out", 32'(sram_dq_out), 32'(ed));
                chk(g, "sram_we_n", 32'(sram_we_n), 32'(ew));
                chk(g, "sram_dq_oe", 32'(sram_dq_oe), 32'(eo));
                if (!ready) begin
                    if (zeros == 0) chk(g, "outstanding", 32'(q.size()), 32'd1);
                    zeros++;
                end else if (zeros > 0) begin
                    chk(g, "freeze_len", 32'(zeros), 32'(2 * W + 1));
                    chk(g, "read_data", read_data, me.rd);
                    if (q.size() > 0) void'(q.pop_front());
                    zeros = 0;
                end
            end
        end

        task automatic issue(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
            exp_t        e;
            logic [31:0] off;
            off  = a - BASE;
            e.wr = w;
            e.lo = {off[18:2], 1'b0};
            e.wd = d;
            if (w) begin
                e.rd = last_rd;
                ref_mem[e.lo[9:0]]         = d[15:0];
                ref_mem[e.lo[9:0] + 10'd1] = d[31:16];
            end else begin
                e.rd    = {ref_mem[e.lo[9:0] + 10'd1], ref_mem[e.lo[9:0]]};
                last_rd = e.rd;
            end
            q.push_back(e);
            wr_en = w; rd_en = r; address = a; write_data = d;
        endtask

        task automatic wait_done();
            bit seen = 1'b0;
            for (int i = 0; i < 4 * W + 8 && !seen; i++) begin
                @(negedge clk);
                if (ready) seen = 1'b1;
            end
            chk(g, "done_seen", 32'(seen), 32'd1);
            @(posedge clk); #1;
        endtask

        task automatic idle(input int n);
            wr_en = 1'b0; rd_en = 1'b0;
            repeat (n) begin @(posedge clk); #1; end
        endtask

        // Reset lands in cycle 2 of a write; the load request is then held.
        task automatic abort_write(input logic [31:0] a, input logic [31:0] d);
            logic [31:0] off;
            logic [15:0] old_hi;
            off    = a - BASE;
            old_hi = ref_mem[{off[10:2], 1'b1}];
            issue(1'b1, 1'b0, a, d);
            if (W > 1) ref_mem[{off[10:2], 1'b1}] = old_hi;
            @(posedge clk); #1; wr_en = 1'b0; rd_en = 1'b1;
            @(posedge clk); #1; rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0; last_rd = 32'd0;
            issue(1'b0, 1'b1, a, 32'd0);
            wait_done();
        endtask

        initial begin : stim
            int kind;
            done = 1'b0; load = 1'b1; rst = 1'b1;
            wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
            last_rd = 32'd0;
            for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
            @(posedge clk); #1; load = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            rst = 1'b0;
            idle(5);
            issue(1'b1, 1'b0, BASE + 32'd8, 32'hDEADBEEF); wait_done();
            issue(1'b0, 1'b1, BASE + 32'd8, 32'd0);        wait_done();
            issue(1'b1, 1'b1, BASE + 32'd16, 32'h1234ABCD); wait_done();
            idle(2);
            issue(1'b0, 1'b1, BASE, 32'd0);                wait_done();
            issue(1'b0, 1'b1, BASE + 32'd4, 32'd0);        wait_done();
            issue(1'b0, 1'b1, BASE + 32'd16, 32'd0);       wait_done();
            idle(3);
            for (int n = 0; n < 40; n++) begin
                kind = $urandom_range(0, 2);
                issue(kind != 0, kind != 1,
                      BASE + 32'($urandom_range(0, 511)) * 32'd4 + 32'($urandom_range(0, 3)),
                      $urandom);
                wait_done();
                idle($urandom_range(0, 2));
            end
            abort_write(BASE + 32'd40, 32'hCAFEF00D);
            idle(4);
            chk(g, "drained", 32'(q.size()), 32'd0);
            done = 1'b1;
        end
    end

    initial begin : summary
        int t = 0;
        while (!(inst[0].done && inst[1].done) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk(2, "all_done", 32'(inst[0].done & inst[1].done), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
